// File: rtl/display_scan_capture.sv
// Captures the digits of a multiplexed 4-digit seven-segment display by snooping its scan buses.
// Also checks the scan order and segment codes, and watches for a stalled anode scan.
module display_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        order_err,
  output logic        code_err,
  output logic        an_err,
  output logic        stalled
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, EXP3, EXP2, EXP1, EXP0} state_t;

  state_t        state, state_nxt;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [SW-1:0] stab_cnt, stab_nxt;
  logic [TW-1:0] stall_cnt, stall_nxt;
  logic          same, capture;
  logic          is_blank, is_digit;
  logic [1:0]    dig_idx;
  logic          code_ok;
  logic [3:0]    code_val;
  logic          frame_c, order_c;

  // Inverted gfedcba pattern to hex value; bit 4 flags a legal code.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (~s)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Stability window: capture fires on the single edge the count reaches STABLE_CYCLES.
  always_comb begin
    same     = (an == an_q) && (seg == seg_q);
    capture  = same && (stab_cnt == SW'(STABLE_CYCLES - 1));
    stab_nxt = stab_cnt;
    if (!same)                                 stab_nxt = SW'(1);
    else if (stab_cnt != SW'(STABLE_CYCLES))   stab_nxt = stab_cnt + SW'(1);
    stall_nxt = stall_cnt;
    if (an != an_q)                            stall_nxt = '0;
    else if (stall_cnt != TW'(TIMEOUT))        stall_nxt = stall_cnt + TW'(1);
  end

  // Anode classification and segment decode on the registered copy.
  always_comb begin
    is_blank = (an_q == 4'b1111);
    is_digit = 1'b1;
    dig_idx  = 2'd0;
    case (an_q)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: is_digit = 1'b0;
    endcase
    {code_ok, code_val} = decode(seg_q);
  end

  // Order tracker next state; a stall abandons any partial frame.
  always_comb begin
    state_nxt = state;
    frame_c   = 1'b0;
    order_c   = 1'b0;
    if (stalled) begin
      state_nxt = IDLE;
    end else if (capture && is_digit) begin
      if (dig_idx == 2'd3) begin
        order_c   = (state == EXP2) || (state == EXP1) || (state == EXP0);
        state_nxt = EXP2;
      end else if (state == EXP2 && dig_idx == 2'd2) begin
        state_nxt = EXP1;
      end else if (state == EXP1 && dig_idx == 2'd1) begin
        state_nxt = EXP0;
      end else if (state == EXP0 && dig_idx == 2'd0) begin
        state_nxt = EXP3;
        frame_c   = 1'b1;
      end else begin
        order_c   = (state != IDLE);
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      stab_cnt    <= '0;
      stall_cnt   <= '0;
      digits      <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      order_err   <= 1'b0;
      code_err    <= 1'b0;
      an_err      <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      an_q       <= an;
      seg_q      <= seg;
      stab_cnt   <= stab_nxt;
      stall_cnt  <= stall_nxt;
      stalled    <= (stall_nxt == TW'(TIMEOUT));
      frame_done <= frame_c;
      order_err  <= order_c;
      code_err   <= 1'b0;
      an_err     <= 1'b0;
      if (capture) begin
        if (is_digit) begin
          if (code_ok) begin
            digits[4*dig_idx +: 4] <= code_val;
            digit_valid[dig_idx]   <= 1'b1;
          end else begin
            code_err <= 1'b1;
          end
        end else if (!is_blank) begin
          an_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: directed scenarios plus random scans against a run-length reference model.
module tb_display_scan_capture;

  localparam int S = 4;
  localparam int T = 50;

  logic        clk, rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done, order_err, code_err, an_err, stalled;

  display_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .digits(digits),
    .digit_valid(digit_valid), .frame_done(frame_done), .order_err(order_err),
    .code_err(code_err), .an_err(an_err), .stalled(stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0, n_fail = 0, frames_seen = 0;

  // Reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [3:0]  m_pulse;   // {frame_done, order_err, code_err, an_err}
  logic        m_stalled;
  logic [10:0] m_prev;
  int          m_len, m_slen, m_exp;   // m_exp: -1 idle, else next expected digit
  logic [3:0]  m_last_an;

  function automatic logic [6:0] seg_of(input int v);
    return ~LIT[v];
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'd1;
    return 4'hF ^ (one << d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_pulse = '0; m_stalled = 1'b0;
    m_prev = {4'hF, 7'h7F}; m_len = 0; m_slen = 0; m_exp = -1; m_last_an = 4'hF;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    int  new_len, zeros, d, v;
    bit  cap, st_prev;
    new_len = ({a, s} == m_prev) ? ((m_len >= S) ? S : m_len + 1) : 1;
    cap     = (new_len == S) && (m_len == S - 1);
    m_prev  = {a, s};
    m_len   = new_len;
    st_prev = m_stalled;
    m_pulse = '0;
    if (st_prev) m_exp = -1;
    zeros = 0; d = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; d = i; end
    if (cap && zeros == 1) begin
      v = -1;
      for (int k = 0; k < 16; k++) if (LIT[k] == ~s) v = k;
      if (v >= 0) begin
        m_digits[4*d +: 4] = 4'(v);
        m_valid[d] = 1'b1;
      end else begin
        m_pulse[1] = 1'b1;
      end
      if (!st_prev) begin
        if (d == 3) begin
          m_pulse[2] = (m_exp >= 0 && m_exp <= 2);
          m_exp = 2;
        end else if (m_exp >= 0 && m_exp <= 2 && d == m_exp) begin
          if (d == 0) begin m_pulse[3] = 1'b1; m_exp = 3; end
          else m_exp = d - 1;
        end else begin
          m_pulse[2] = (m_exp != -1);
          m_exp = -1;
        end
      end
    end else if (cap && zeros > 1) begin
      m_pulse[0] = 1'b1;
    end
    m_slen    = (a != m_last_an) ? 0 : ((m_slen >= T) ? T : m_slen + 1);
    m_last_an = a;
    m_stalled = (m_slen == T);
  endtask

  task automatic check_all();
    chk("digits", 32'(digits), 32'(m_digits));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("pulses", 32'({frame_done, order_err, code_err, an_err}), 32'(m_pulse));
    chk("stalled", 32'(stalled), 32'(m_stalled));
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an = a; seg = s;
    @(posedge clk); #1;
    model_edge(a, s);
    if (frame_done === 1'b1) frames_seen++;
    check_all();
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s);
  endtask

  task automatic apply_reset();
    rst = 1'b1; #1;
    model_reset();
    check_all();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int dg, r, dw;
    logic [3:0] a;
    logic [6:0] s;
    an = 4'hF; seg = 7'h7F; rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // One cycle short of the window on every digit: nothing captured
    for (int d = 3; d >= 0; d--) hold(an_of(d), seg_of(d + 5), S - 1);
    chk("short_dwell_digits", 32'(digits), 32'h0);

    // Full frame 1,2,3,4
    frames_seen = 0;
    for (int d = 3; d >= 0; d--) hold(an_of(d), seg_of(4 - d), 10);
    chk("frame_digits", 32'(digits), 32'h1234);
    chk("frame_valid", 32'(digit_valid), 32'hF);
    chk("frame_count", 32'(frames_seen), 32'd1);

    // 3,2,0 is out of order; 3,2,1,0 completes a frame
    frames_seen = 0;
    hold(an_of(3), seg_of(9), 6); hold(an_of(2), seg_of(8), 6); hold(an_of(0), seg_of(7), 6);
    chk("skip_frames", 32'(frames_seen), 32'd0);
    for (int d = 3; d >= 0; d--) hold(an_of(d), seg_of(d + 10), 6);
    chk("recover_frames", 32'(frames_seen), 32'd1);

    // All segments lit decodes 8, then an illegal pattern leaves d2 alone
    hold(an_of(2), 7'h00, 6);
    hold(an_of(2), 7'b0110110, 6);
    chk("d2_kept", 32'(digits[11:8]), 32'h8);

    // Two anodes low, held until the stall timer expires
    hold(4'b1001, seg_of(1), T + 5);
    chk("stall_set", 32'(stalled), 32'd1);
    step(an_of(0), seg_of(1));
    chk("stall_clear", 32'(stalled), 32'd0);

    // Reset in the middle of a dwell, then a fresh scan
    hold(an_of(3), seg_of(5), 10); hold(an_of(2), seg_of(6), 2);
    apply_reset();
    for (int d = 3; d >= 0; d--) hold(an_of(d), seg_of(d), 5);

    // Random scans, mostly in order
    dg = 0;
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 19);
      dg = (r < 15) ? (dg + 3) % 4 : $urandom_range(0, 3);
      a  = an_of(dg);
      if (r == 18) a = 4'hF;
      if (r == 19) a = 4'($urandom);
      s  = ($urandom_range(0, 9) < 8) ? seg_of($urandom_range(0, 15)) : 7'($urandom);
      dw = $urandom_range(2, 7);
      hold(a, s, dw);
      if (i == 120) apply_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
